// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes the instruction into an ALU control code and operands d1/d2,
// and holds them in a one-entry valid/ready output slot. Perf counters are built only with ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned LINK_OFFSET = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] d1,
  output logic [XLEN-1:0] d2,
  output logic [3:0]      control,
  output logic            illegal,
  output logic [31:0]     issued_count,
  output logic [15:0]     illegal_count
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] i_imm, s_imm, u_imm, shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign i_imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign s_imm  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm  = {instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

  function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_ctrl = ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLT;
      3'b011:  f3_ctrl = ALU_SLTU;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase
  endfunction

  logic [XLEN-1:0] dec_d1, dec_d2;
  logic [3:0]      dec_ctrl;
  logic            dec_ill;

  always_comb begin
    dec_d1   = rs1_data;
    dec_d2   = rs2_data;
    dec_ctrl = ALU_ADD;
    dec_ill  = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == F7_BASE)                          dec_ctrl = f3_ctrl(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)  dec_ctrl = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)  dec_ctrl = ALU_SRA;
        else                                            dec_ill  = 1'b1;
      end
      7'b0010011: begin
        dec_d2   = i_imm;
        dec_ctrl = f3_ctrl(funct3);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_d2 = shamt;
          if (funct3 == 3'b101 && funct7 == F7_ALT) dec_ctrl = ALU_SRA;
          else if (funct7 != F7_BASE)               dec_ill  = 1'b1;
        end
      end
      7'b0110111: begin
        dec_d1 = '0;
        dec_d2 = u_imm;
      end
      7'b0010111: begin
        dec_d1 = pc;
        dec_d2 = u_imm;
      end
      7'b0000011: begin
        dec_d2  = i_imm;
        dec_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0100011: begin
        dec_d2  = s_imm;
        dec_ill = funct3 > 3'b010;
      end
      7'b1100011: begin
        case (funct3[2:1])
          2'b00:   dec_ctrl = ALU_SUB;
          2'b10:   dec_ctrl = ALU_SLT;
          2'b11:   dec_ctrl = ALU_SLTU;
          default: dec_ill  = 1'b1;
        endcase
      end
      7'b1101111, 7'b1100111: begin
        dec_d1  = pc;
        dec_d2  = XLEN'(LINK_OFFSET);
        dec_ill = (opcode == 7'b1100111) && (funct3 != 3'b000);
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal beats still travel down the pipe, but with neutral operands.
    if (dec_ill) begin
      dec_d1   = '0;
      dec_d2   = '0;
      dec_ctrl = ALU_ADD;
    end
  end

  logic            valid_q, valid_d;
  logic [XLEN-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            ill_q, ill_d;
  logic            accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      d1_d    = dec_d1;
      d2_d    = dec_d2;
      ctrl_d  = dec_ctrl;
      ill_d   = dec_ill;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      ctrl_q  <= ALU_ADD;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = valid_q;
  assign d1        = d1_q;
  assign d2        = d2_q;
  assign control   = ctrl_q;
  assign illegal   = ill_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issued_q, issued_d;
  logic [15:0] illcnt_q, illcnt_d;

  always_comb begin
    issued_d = issued_q;
    illcnt_d = illcnt_q;
    if (accept) begin
      if (dec_ill) illcnt_d = illcnt_q + 16'd1;
      else         issued_d = issued_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      illcnt_q <= '0;
    end else begin
      issued_q <= issued_d;
      illcnt_q <= illcnt_d;
    end
  end

  assign issued_count  = issued_q;
  assign illegal_count = illcnt_q;
`else
  assign issued_count  = '0;
  assign illegal_count = '0;
`endif

endmodule
